// File: rtl/axis_arb_pkg.sv
// Shared arbitration types and the round-robin priority search used by
// axis_rr_arbiter and future arbiters (supports up to 16 requesters).
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_REQ = 16;

  // Lowest requester strictly above 'last' wins; otherwise wrap to the lowest
  // requester overall. Requests above the real source count must be zero.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last);
    logic [15:0] hi_mask;
    logic [3:0]  pick;
    hi_mask = ~((16'd2 << last) - 16'd1);
    pick    = last;
    for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
      if (req[i]) pick = 4'(i);
    end
    for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
      if (req[i] && hi_mask[i]) pick = 4'(i);
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream register slice with full throughput; the payload
// is opaque so callers concatenate whatever fields travel with the data.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_vld_p1;
  logic [W-1:0] r_data_p1;

  assign o_ready = !r_vld_p1 || i_ready;

  // stage p1: registered output, driven only by flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else if (o_ready) begin
      r_vld_p1 <= i_valid;
      if (i_valid) r_data_p1 <= i_data;
    end
  end

  assign o_valid = r_vld_p1;
  assign o_data  = r_data_p1;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin merge of NUM_SRC AXI-Stream inputs onto one
// registered output. Optional macro AXIS_ARB_SRC_TAG_EN drives m_tid with the source index.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 1,
  parameter int DEST_W  = 1,
  parameter int USER_W  = 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_SRC-1:0]           s_tvalid,
  output logic [NUM_SRC-1:0]           s_tready,
  input  logic [NUM_SRC*DATA_W-1:0]    s_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0]  s_tstrb,
  input  logic [NUM_SRC*DATA_W/8-1:0]  s_tkeep,
  input  logic [NUM_SRC-1:0]           s_tlast,
  input  logic [NUM_SRC*ID_W-1:0]      s_tid,
  input  logic [NUM_SRC*DEST_W-1:0]    s_tdest,
  input  logic [NUM_SRC*USER_W-1:0]    s_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic [DATA_W/8-1:0]          m_tstrb,
  output logic [DATA_W/8-1:0]          m_tkeep,
  output logic                         m_tlast,
  output logic [ID_W-1:0]              m_tid,
  output logic [DEST_W-1:0]            m_tdest,
  output logic [USER_W-1:0]            m_tuser,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         busy
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int KW = DATA_W / 8;
  localparam int PW = DATA_W + 2 * KW + 1 + ID_W + DEST_W + USER_W;

  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_num_src_check
    $error("axis_rr_arbiter: NUM_SRC must be in 2..16");
  end

  arb_state_t          r_state, w_state_nxt;
  logic [GW-1:0]       r_grant, w_grant_nxt;
  logic [GW-1:0]       r_last_grant, w_last_nxt;

  logic                w_sel_valid;
  logic [DATA_W-1:0]   w_sel_data;
  logic [KW-1:0]       w_sel_strb;
  logic [KW-1:0]       w_sel_keep;
  logic                w_sel_last;
  logic [ID_W-1:0]     w_sel_tid;
  logic [DEST_W-1:0]   w_sel_dest;
  logic [USER_W-1:0]   w_sel_user;
  logic [ID_W-1:0]     w_tid;

  logic                w_s_valid;
  logic                w_in_ready;
  logic                w_load;
  logic [PW-1:0]       w_s_payload;
  logic [PW-1:0]       w_m_payload;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_strb  = '0;
    w_sel_keep  = '0;
    w_sel_last  = 1'b0;
    w_sel_tid   = '0;
    w_sel_dest  = '0;
    w_sel_user  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (GW'(i) == r_grant) begin
        w_sel_valid = s_tvalid[i];
        w_sel_data  = s_tdata[i*DATA_W +: DATA_W];
        w_sel_strb  = s_tstrb[i*KW +: KW];
        w_sel_keep  = s_tkeep[i*KW +: KW];
        w_sel_last  = s_tlast[i];
        w_sel_tid   = s_tid[i*ID_W +: ID_W];
        w_sel_dest  = s_tdest[i*DEST_W +: DEST_W];
        w_sel_user  = s_tuser[i*USER_W +: USER_W];
      end
    end
  end

`ifdef AXIS_ARB_SRC_TAG_EN
  if (ID_W < GW) begin : g_id_w_check
    $error("axis_rr_arbiter: ID_W too narrow to carry the source tag");
  end
  assign w_tid = ID_W'(r_grant);
`else
  assign w_tid = w_sel_tid;
`endif

  // Grant is held until the granted source's tlast beat is accepted, so a
  // source that pauses mid-packet keeps the output to itself.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    s_tready    = '0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|s_tvalid) begin
          w_grant_nxt = GW'(rr_next(16'(s_tvalid), 4'(r_last_grant)));
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (GW'(i) == r_grant) s_tready[i] = w_in_ready;
        end
        w_load = w_sel_valid && w_in_ready;
        if (w_load && w_sel_last) begin
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_SRC - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  assign w_s_valid   = (r_state == PASS) && w_sel_valid;
  assign w_s_payload = {w_sel_data, w_sel_strb, w_sel_keep, w_sel_last,
                        w_tid, w_sel_dest, w_sel_user};

  // stage p1: output register slice
  axis_reg_slice #(
    .W (PW)
  ) u_out_slice (
    .clk     (aclk),
    .rst     (areset),
    .i_valid (w_s_valid),
    .o_ready (w_in_ready),
    .i_data  (w_s_payload),
    .o_valid (m_tvalid),
    .i_ready (m_tready),
    .o_data  (w_m_payload)
  );

  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = w_m_payload;
  assign grant_idx = r_grant;
  assign busy      = (r_state == PASS);

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that merges `NUM_SRC` AXI-Stream slave inputs onto one AXI-Stream master output. A grant is held from a packet's first beat through the beat carrying `tlast`, so packets are never interleaved. It sits between several `axis_if` producers (for example master BFMs or DMA channels) and a single shared downstream consumer, and drives the consumer through a registered output stage.

## Interface
- `NUM_SRC`, 4: number of slave inputs, 2..16.
- `DATA_W`, 32: tdata width; multiple of 8.
- `ID_W`, 1: tid width.
- `DEST_W`, 1: tdest width.
- `USER_W`, 1: tuser width.
- `aclk`  in  1  clock; all logic is rising-edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_tvalid`  in  NUM_SRC  per-source valid.
- `s_tready`  out  NUM_SRC  per-source ready.
- `s_tdata`  in  NUM_SRC×DATA_W  per-source data.
- `s_tstrb`, `s_tkeep`  in  NUM_SRC×DATA_W/8  per-source byte qualifiers.
- `s_tlast`  in  NUM_SRC  per-source end of packet.
- `s_tid`  in  NUM_SRC×ID_W; `s_tdest`  in  NUM_SRC×DEST_W; `s_tuser`  in  NUM_SRC×USER_W.
- `m_tvalid`  out  1; `m_tready`  in  1.
- `m_tdata`  out  DATA_W; `m_tstrb`, `m_tkeep`  out  DATA_W/8; `m_tlast`  out  1.
- `m_tid`  out  ID_W (see Configuration); `m_tdest`  out  DEST_W; `m_tuser`  out  USER_W.
- `grant_idx`  out  $clog2(NUM_SRC)  currently or last granted source (debug/status).
- `busy`  out  1  high while in state PASS.

## Operation
- FSM has two states, IDLE and PASS.
- In IDLE, all `s_tready` are 0. If any `s_tvalid` is set, the arbiter grants the first requester found searching upward (with wrap-around) from `last_grant+1`. `grant_idx` takes that value and the FSM moves to PASS on the next edge.
- In PASS, only `s_tready[grant_idx]` may be 1. It equals the input-ready of the output register. All other `s_tready` are 0.
- A beat is accepted on `s_tvalid[g] && s_tready[g]`. An accepted beat with `s_tlast[g]=1` sets `last_grant<=g` and returns the FSM to IDLE.
- A requester dropping `s_tvalid` mid-packet does not release the grant. The FSM waits in PASS for `tlast`.
- Output register is one entry with full throughput. Its input-ready is `!m_tvalid || m_tready`. A beat loads when accepted. `m_tvalid` clears when the register drains with no new load.
- All sideband fields (strb, keep, last, id, dest, user) are carried unchanged with tdata.
- Reset (asynchronous, any time, including mid-packet): FSM goes to IDLE and `last_grant` to NUM_SRC-1, so source 0 has first priority. A partially forwarded packet is discarded. There is no recovery of a truncated packet; this is by design.

## Timing
- Reset values: `m_tvalid=0`, `m_tdata/tstrb/tkeep/tlast/tid/tdest/tuser=0`, `s_tready=0`, `grant_idx=0`, `busy=0`.
- Arbitration costs one cycle: the cycle after a packet's `tlast` is accepted, every `s_tready` is 0.
- Input-to-output latency is 1 cycle. With `m_tready` held high in PASS, throughput is 1 beat/cycle.
- `m_*` holds stable while `m_tvalid && !m_tready`, per AXI-Stream.
- No combinational path from `m_tready` to any `m_*` output. `m_tready` does reach `s_tready[g]` combinationally.
- A single-beat packet occupies 1 cycle in IDLE and 1 cycle in PASS.

## Configuration
- `AXIS_ARB_SRC_TAG_EN`
  - Defined: `m_tid` is driven with the granted source index, zero-extended to ID_W. `s_tid` is ignored. Elaboration fails if ID_W < $clog2(NUM_SRC).
  - Undefined: `m_tid` passes `s_tid[g]` through unchanged.

## Structure
- `axis_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, PASS};
  - a `rr_next` function (mask-and-wrap priority search) shared with future arbiters.
- Sub-module `axis_reg_slice`: the single-entry output register with parameterised payload width. The arbiter instantiates it once on the concatenated payload.

## Test plan
- Reset, then source 1 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with tlast) -> m_* emits the same three beats in order with tlast on 0xA2; `grant_idx=1`; `busy` falls one cycle after the last accept.
- All 4 sources hold continuous 2-beat packets -> grant order is 0,1,2,3,0 and no beats from different sources are interleaved.
- Source 2 stalls `s_tvalid` for 5 cycles mid-packet while source 3 requests -> grant stays on 2 until its tlast, then goes to 3.
- `m_tready` toggles 1010… during a 4-beat packet -> no beat is lost or duplicated, and m_* is stable while stalled.
- `areset` is pulsed during beat 2 of a packet -> all outputs read 0 immediately; after release, source 0 is granted first.
- `AXIS_ARB_SRC_TAG_EN` defined, source 3 sends with s_tid=0 -> m_tid=3 on every beat.
